// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_if
//  Description : Bundle of the request/response handshake and the SRAM port
//                seen by the load/store unit.
//                slave  - view taken by mem_lsu
//                master - view taken by the processor side / SRAM model
//  Ports       : REQ_VALID/READY/WE/FUNCT3/ADDR/WDATA  request channel
//                RSP_VALID/RDATA/ERR                    response channel
//                MEM_CSN/ADDR/WE/BE/DI/DO               SRAM word port
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_lsu_if #(
  parameter int ADDR_W = 12
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WE;
  logic [2:0]        REQ_FUNCT3;
  logic [31:0]       REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERR;
  logic              MEM_CSN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_WE;
  logic [3:0]        MEM_BE;
  logic [31:0]       MEM_DI;
  logic [31:0]       MEM_DO;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_DO,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output MEM_CSN, MEM_ADDR, MEM_WE, MEM_BE, MEM_DI
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA, MEM_DO,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  MEM_CSN, MEM_ADDR, MEM_WE, MEM_BE, MEM_DI
  );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : RV32 load/store unit in front of one port of a word SRAM
//                with one-cycle read latency. Handles byte/half/word loads
//                and stores including misaligned accesses spanning two
//                words. Every store other than an aligned SW is a full-word
//                read-modify-write because the SRAM does not keep
//                unselected lanes on write.
//  Ports       : CLK   clock, rising edge
//                RSTn  synchronous active-low reset
//                bus   mem_lsu_if.slave (request, response, SRAM port)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lsu #(
  parameter int ADDR_W = 12
) (
  input  logic     CLK,
  input  logic     RSTn,
  mem_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_CAP  = 3'd3,
    S_WRA  = 3'd4,
    S_WRB  = 3'd5,
    S_RESP = 3'd6
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [2:0]        r_size;
  logic              r_span;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_wa;
  logic [31:0]       r_wb;
  logic [31:0]       r_rdata;
  logic              r_err;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // --------------------------------------------------------------------------
  logic [2:0] w_size;
  logic       w_legal;
  logic       w_span;
  logic       w_aligned_sw;
  logic       w_unused_addr;

  always_comb begin
    case (bus.REQ_FUNCT3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  assign w_legal = bus.REQ_WE ? (bus.REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010})
                              : (bus.REQ_FUNCT3 inside {3'b000, 3'b001, 3'b010,
                                                        3'b100, 3'b101});
  assign w_span       = ({2'b00, bus.REQ_ADDR[1:0]} + {1'b0, w_size}) > 4'd4;
  assign w_aligned_sw = bus.REQ_WE && (bus.REQ_ADDR[1:0] == 2'b00) &&
                        (bus.REQ_FUNCT3[1:0] == 2'b10);

  // Address bits above the SRAM word address are deliberately ignored.
  assign w_unused_addr = ^bus.REQ_ADDR[31:ADDR_W+2];

  // --------------------------------------------------------------------------
  // Load extraction. In CAP the last word is still on MEM_DO, so the result
  // is formed from the live SRAM data rather than the capture registers.
  // --------------------------------------------------------------------------
  logic [63:0] w_ld64;
  logic [31:0] w_ld_sh;
  logic [31:0] w_load;

  assign w_ld64  = r_span ? {bus.MEM_DO, r_wa} : {32'h0, bus.MEM_DO};
  assign w_ld_sh = w_ld64[{r_off, 3'b000} +: 32];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_ld_sh[7]}},  w_ld_sh[7:0]};
      3'b001:  w_load = {{16{w_ld_sh[15]}}, w_ld_sh[15:0]};
      3'b100:  w_load = {24'h0, w_ld_sh[7:0]};
      3'b101:  w_load = {16'h0, w_ld_sh[15:0]};
      default: w_load = w_ld_sh;
    endcase
  end

  // --------------------------------------------------------------------------
  // Store merge: lanes [off, off+size) of {B,A} take store bytes 0..size-1.
  // For an aligned SW all four low lanes are replaced, so no read is needed.
  // --------------------------------------------------------------------------
  logic [63:0] w_rd64;
  logic [63:0] w_merged;
  logic [3:0]  w_lane_lo;
  logic [3:0]  w_lane_hi;

  assign w_rd64    = {r_wb, r_wa};
  assign w_lane_lo = {2'b00, r_off};
  assign w_lane_hi = w_lane_lo + {1'b0, r_size};

  always_comb begin
    w_merged = w_rd64;
    for (int i = 0; i < 8; i++) begin
      if (({1'b0, 3'(i)} >= w_lane_lo) && ({1'b0, 3'(i)} < w_lane_hi))
        w_merged[8*i +: 8] = r_wdata[{2'(i) - r_off, 3'b000} +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_size   <= 3'd0;
      r_span   <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= 32'h0;
      r_wa     <= 32'h0;
      r_wb     <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.REQ_VALID) begin
            r_we     <= bus.REQ_WE;
            r_funct3 <= bus.REQ_FUNCT3;
            r_off    <= bus.REQ_ADDR[1:0];
            r_size   <= w_size;
            r_span   <= w_span;
            r_waddr  <= bus.REQ_ADDR[ADDR_W+1:2];
            r_wdata  <= bus.REQ_WDATA;
            r_wa     <= 32'h0;
            // B stays zero for non-spanning accesses
            r_wb     <= 32'h0;
            if (!w_legal) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
              r_state <= S_RESP;
            end else if (w_aligned_sw) begin
              r_state <= S_WRA;
            end else begin
              r_state <= S_RDA;
            end
          end
        end
        S_RDA: r_state <= r_span ? S_RDB : S_CAP;
        S_RDB: begin
          r_wa    <= bus.MEM_DO;
          r_state <= S_CAP;
        end
        S_CAP: begin
          if (r_span) r_wb <= bus.MEM_DO;
          else        r_wa <= bus.MEM_DO;
          if (!r_we) begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WRA;
          end
        end
        S_WRA: begin
          if (r_span) begin
            r_state <= S_WRB;
          end else begin
            r_rdata <= 32'h0;
            r_state <= S_RESP;
          end
        end
        S_WRB: begin
          r_rdata <= 32'h0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the state register only
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_waddr_b;
  assign w_waddr_b = r_waddr + ADDR_W'(1);  // wraps at the top word

  always_comb begin
    bus.MEM_CSN  = 1'b1;
    bus.MEM_WE   = 1'b0;
    bus.MEM_BE   = 4'h0;
    bus.MEM_ADDR = '0;
    bus.MEM_DI   = 32'h0;
    case (r_state)
      S_RDA: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_BE   = 4'hF;
        bus.MEM_ADDR = r_waddr;
      end
      S_RDB: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_BE   = 4'hF;
        bus.MEM_ADDR = w_waddr_b;
      end
      S_WRA: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_WE   = 1'b1;
        bus.MEM_BE   = 4'hF;
        bus.MEM_ADDR = r_waddr;
        bus.MEM_DI   = w_merged[31:0];
      end
      S_WRB: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_WE   = 1'b1;
        bus.MEM_BE   = 4'hF;
        bus.MEM_ADDR = w_waddr_b;
        bus.MEM_DI   = w_merged[63:32];
      end
      default: ;
    endcase
  end

  assign bus.REQ_READY = (r_state == S_IDLE);
  assign bus.RSP_VALID = (r_state == S_RESP);
  assign bus.RSP_RDATA = r_rdata;
  assign bus.RSP_ERR   = r_err;

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store unit between the processor data-access request and one port of the dual-port word SRAM. Takes byte-addressed RV32 loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW), including misaligned accesses that span two words, and converts them into SRAM word accesses. The SRAM port has a one-cycle read latency and does not preserve unselected byte lanes on write. The block therefore always reads with BE=4'hF, and performs every store that is not an aligned word store as a full-word read-modify-write.

Parameters:
ADDR_W, 12, SRAM word-address width; byte address bits [ADDR_W+1:2] form the word address, higher bits are ignored.

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  synchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  high only in IDLE; transfer when REQ_VALID && REQ_READY
REQ_WE  in  1  1=store, 0=load
REQ_FUNCT3  in  3  RV32 funct3 (size/sign)
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, LSB-aligned
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  32  load result (0 for stores/errors)
RSP_ERR  out  1  illegal funct3, qualified by RSP_VALID
MEM_CSN  out  1  SRAM chip select, active low
MEM_ADDR  out  ADDR_W  SRAM word address
MEM_WE  out  1  SRAM write enable
MEM_BE  out  4  SRAM byte enables
MEM_DI  out  32  SRAM write data
MEM_DO  in  32  SRAM read data; valid the cycle after a read is sampled

Behaviour:
- Request fields are captured on the accept edge. Inputs are ignored while not in IDLE.
- Access geometry:
  - size s = 1/2/4 from funct3[1:0]; offset o = addr[1:0].
  - wA = addr[ADDR_W+1:2]; wB = wA+1 mod 2^ADDR_W (wraps at the top word).
  - span = (o+s > 4).
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Anything else -> IDLE->RESP with RSP_ERR=1, RSP_RDATA=0, and no SRAM access.
- States: IDLE, RDA, RDB, CAP, WRA, WRB, RESP. The MEM_* outputs are decoded from the state register.
  - RDA: CSN=0, WE=0, BE=F, ADDR=wA.
  - RDB: same as RDA with ADDR=wB; word A is captured from MEM_DO on exit.
  - CAP: no access; captures MEM_DO into word A (no span) or word B (span).
  - WRA / WRB: CSN=0, WE=1, BE=F, ADDR=wA/wB, DI=merged word.
  - All other states: CSN=1, WE=0, BE=0, ADDR=0, DI=0.
- Transitions:
  - IDLE -> RDA on a legal accept, except aligned SW (o=0, s=4), which goes IDLE -> WRA with DI=REQ_WDATA.
  - RDA -> RDB if span, else RDA -> CAP.
  - RDB -> CAP.
  - CAP -> RESP for a load; CAP -> WRA for a store.
  - WRA -> WRB if span, else WRA -> RESP.
  - WRB -> RESP.
  - RESP -> IDLE, with RSP_VALID=1 for exactly one cycle.
- Load data: form the 64-bit value {B,A} (B=0 if no span), shift right by 8*o, take s bytes, then sign-extend (000/001) or zero-extend (100/101). RSP_RDATA is registered on CAP exit and holds until the next response.
- Store merge: in {B,A}, byte lanes o..o+s-1 are replaced by REQ_WDATA bytes 0..s-1, little-endian. The other lanes keep their read values.
- Latency, counted from the accept cycle (0), RSP_VALID is high in:
  - cycle 3 for an aligned load;
  - cycle 4 for a spanning load;
  - cycle 2 for an aligned SW;
  - cycle 4 for a sub-word non-spanning store;
  - cycle 6 for a spanning store;
  - cycle 1 for an error.
- Reset values: state=IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, MEM_CSN=1, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.
- Reset mid-operation: the operation is abandoned and no response is produced. The SRAM is deselected from the edge that samples RSTn=0. A spanning store reset after WRA leaves word A updated and word B unchanged (accepted).

Test Plan:
1. Preload word[4]=0x8899AABB. LW addr 0x10 -> one read of ADDR=4, RSP_VALID in cycle 3, RSP_RDATA=0x8899AABB, RSP_ERR=0.
2. LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
3. word[5]=0x11223344. LW 0x12 -> reads ADDR 4 then 5, RSP_VALID in cycle 4, RSP_RDATA=0x33448899.
4. SB 0x11 with WDATA=0x000000CC -> read ADDR 4, then write with BE=F and DI=0x8899CCBB. A following LW 0x10 returns 0x8899CCBB. Aligned SW 0x14 with 0xDEADBEEF -> a single write, no read, RSP_VALID in cycle 2.
5. Wrap case: word[0xFFF]=0x01020304, word[0]=0x0A0B0C0D, SH 0x3FFF with 0x5566 -> word[0xFFF]=0x66020304 and word[0]=0x0A0B0C55. A following LHU 0x3FFF returns 0x00005566.
6. Load with funct3=011 -> RSP_VALID in cycle 1, RSP_ERR=1, RSP_RDATA=0, MEM_CSN stays 1. Separately, RSTn=0 during RDB -> next cycle IDLE, MEM_CSN=1, REQ_READY=1, no RSP_VALID.
